// File: rtl/ui_pkg.sv
// Shared definitions for the button front end: channel indices, default and
// reduced timing sets, and the per-channel event bundle.
package ui_pkg;

  localparam int BTN_R   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_U   = 2;
  localparam int BTN_D   = 3;
  localparam int BTN_C   = 4;
  localparam int NUM_BTN = 5;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 2**20;
  localparam int DEF_REPEAT_DELAY    = 2**26;
  localparam int DEF_REPEAT_PERIOD   = 2**22;
  localparam int DEF_LONG_COUNT      = 2**27;

  // Short timing so a whole hold/repeat/long sequence fits in a few dozen cycles.
  localparam int SIM_SYNC_STAGES     = 2;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_PERIOD   = 3;
  localparam int SIM_LONG_COUNT      = 20;

  typedef struct packed {
    logic level;
    logic press;
    logic released;
    logic move;
    logic longp;
  } btn_evt_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce, edge pulses, auto-repeat
// schedule and a one-shot long-press pulse.
module btn_channel
  import ui_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int LONG_COUNT      = DEF_LONG_COUNT
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     noisy_i,
  input  logic     repeat_en_i,
  output btn_evt_t evt_o
);

  localparam int HOLD_MAX = max_int(LONG_COUNT, REPEAT_DELAY);
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam int PW       = $clog2(REPEAT_PERIOD + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_MAX);
  localparam logic [HW-1:0] DELAY_AT  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] LONG_AT   = HW'(LONG_COUNT);
  localparam logic [PW-1:0] PERIOD_AT = PW'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic [HW-1:0]          hold_q, hold_d, hold_n;
  logic [PW-1:0]          per_q, per_d, per_n;
  logic                   armed_q, armed_d;
  logic                   rep_hit_q, rep_hit_d;
  logic                   long_q, long_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = hold_q;
    per_d     = per_q;
    armed_d   = armed_q;
    rep_hit_d = 1'b0;
    long_d    = 1'b0;
    hold_n    = (hold_q == HOLD_TOP) ? hold_q : hold_q + HW'(1);
    per_n     = per_q + PW'(1);

    if (sync_s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end

    // Until the first repeat, the hold counter drives the schedule; afterwards
    // the reloading period counter takes over so saturation of hold is harmless.
    if (level_d && !level_q) begin
      press_d = 1'b1;
      hold_d  = '0;
      per_d   = '0;
      armed_d = 1'b0;
    end else if (!level_d && level_q) begin
      release_d = 1'b1;
      hold_d    = '0;
      per_d     = '0;
      armed_d   = 1'b0;
    end else if (level_q) begin
      hold_d = hold_n;
      long_d = (hold_q < LONG_AT) && (hold_n == LONG_AT);
      if (!armed_q) begin
        if (hold_n == DELAY_AT) begin
          rep_hit_d = 1'b1;
          armed_d   = 1'b1;
          per_d     = '0;
        end else begin
          per_d = '0;
        end
      end else if (per_n == PERIOD_AT) begin
        rep_hit_d = 1'b1;
        per_d     = '0;
      end else begin
        per_d = per_n;
      end
    end else begin
      hold_d  = '0;
      per_d   = '0;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= '0;
      per_q     <= '0;
      armed_q   <= 1'b0;
      rep_hit_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], noisy_i};
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      per_q     <= per_d;
      armed_q   <= armed_d;
      rep_hit_q <= rep_hit_d;
      long_q    <= long_d;
    end
  end

  // The repeat schedule is registered; only the enable is applied in the pulse cycle itself.
  assign evt_o.level    = level_q;
  assign evt_o.press    = press_q;
  assign evt_o.released = release_q;
  assign evt_o.move     = press_q | (rep_hit_q & repeat_en_i);
  assign evt_o.longp    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button front end: one independent btn_channel per input bit,
// outputs regrouped into per-event vectors.
module btn_conditioner
  import ui_pkg::*;
#(
  parameter int NUM_CH          = NUM_BTN,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int LONG_COUNT      = DEF_LONG_COUNT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] noisy_in,
  input  logic [NUM_CH-1:0] repeat_en_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] press_out,
  output logic [NUM_CH-1:0] release_out,
  output logic [NUM_CH-1:0] move_out,
  output logic [NUM_CH-1:0] long_out
);

  btn_evt_t evt_s [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .LONG_COUNT     (LONG_COUNT)
    ) u_ch (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .noisy_i    (noisy_in[i]),
      .repeat_en_i(repeat_en_in[i]),
      .evt_o      (evt_s[i])
    );

    assign level_out[i]   = evt_s[i].level;
    assign press_out[i]   = evt_s[i].press;
    assign release_out[i] = evt_s[i].released;
    assign move_out[i]    = evt_s[i].move;
    assign long_out[i]    = evt_s[i].longp;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with short timing: rule-level model checked every
// cycle, plus directed scenarios with literal pulse-train expectations.
module tb_btn_conditioner;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LC  = 20;
  localparam int HIST = 2048;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] noisy = '0;
  logic [NCH-1:0] en = '0;
  logic [NCH-1:0] level_o, press_o, release_o, move_o, long_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mv_mask [NCH];
  logic [31:0] lg_mask [NCH];
  int rel [NCH];
  int pr_cnt [NCH];
  int pr_cyc [NCH];
  int rl_cnt [NCH];
  int rl_cyc [NCH];

  btn_conditioner #(
    .NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .LONG_COUNT(LC)
  ) dut (
    .clk_in(clk), .rst_in(rst), .noisy_in(noisy), .repeat_en_in(en),
    .level_out(level_o), .press_out(press_o), .release_out(release_o),
    .move_out(move_o), .long_out(long_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a level changes once the input seen SS edges late has disagreed
  // with it for DB edges in a row; hold time counts up from the press cycle.
  initial begin : model_and_compare
    logic [NCH-1:0] smp [HIST];
    logic           m_lvl [NCH];
    logic           m_rose [NCH];
    logic           m_fell [NCH];
    int             m_run [NCH];
    int             m_h [NCH];
    int             rst_edge;
    logic           s;
    logic [NCH-1:0] e_lvl, e_pr, e_rl, e_mv, e_lg;
    rst_edge = 0;
    for (int i = 0; i < NCH; i++) begin
      m_lvl[i] = 1'b0; m_rose[i] = 1'b0; m_fell[i] = 1'b0;
      m_run[i] = 0; m_h[i] = -1;
      rel[i] = 99; pr_cnt[i] = 0; pr_cyc[i] = -1; rl_cnt[i] = 0; rl_cyc[i] = -1;
      mv_mask[i] = '0; lg_mask[i] = '0;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      smp[cyc % HIST] = noisy;
      if (rst) begin
        rst_edge = cyc;
        for (int i = 0; i < NCH; i++) begin
          m_lvl[i] = 1'b0; m_rose[i] = 1'b0; m_fell[i] = 1'b0;
          m_run[i] = 0; m_h[i] = -1;
        end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          s = (cyc - SS > rst_edge) ? smp[(cyc - SS) % HIST][i] : 1'b0;
          m_rose[i] = 1'b0;
          m_fell[i] = 1'b0;
          if (s != m_lvl[i]) m_run[i]++;
          else m_run[i] = 0;
          if (m_run[i] == DB) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            if (m_lvl[i]) m_rose[i] = 1'b1;
            else m_fell[i] = 1'b1;
          end
          if (m_rose[i]) m_h[i] = 0;
          else if (m_lvl[i]) m_h[i]++;
          else m_h[i] = -1;
        end
      end

      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        e_lvl[i] = m_lvl[i];
        e_pr[i]  = m_rose[i];
        e_rl[i]  = m_fell[i];
        e_lg[i]  = m_lvl[i] && (m_h[i] == LC);
        e_mv[i]  = m_lvl[i] && ((m_h[i] == 0) ||
                   (en[i] && (m_h[i] >= RD) && ((m_h[i] - RD) % RP == 0)));
      end
      check("level_out", 32'(level_o), 32'(e_lvl));
      check("press_out", 32'(press_o), 32'(e_pr));
      check("release_out", 32'(release_o), 32'(e_rl));
      check("move_out", 32'(move_o), 32'(e_mv));
      check("long_out", 32'(long_o), 32'(e_lg));

      for (int i = 0; i < NCH; i++) begin
        if (press_o[i]) begin
          rel[i] = 0; mv_mask[i] = '0; lg_mask[i] = '0;
          pr_cnt[i]++; pr_cyc[i] = cyc;
        end
        if (rel[i] < 32) begin
          mv_mask[i][rel[i]] = move_o[i];
          lg_mask[i][rel[i]] = long_o[i];
          rel[i]++;
        end
        if (release_o[i]) begin
          rl_cnt[i]++; rl_cyc[i] = cyc;
        end
      end
    end
  end

  // Raise a channel for n_high cycles; enable is on from the start when en_at <= 0,
  // otherwise raised in the cycle whose hold time equals en_at.
  task automatic hold(input int ch, input int n_high, input int en_at,
                      input logic [31:0] exp_mv, input logic [31:0] exp_lg, input string nm);
    int c0;
    int fall;
    noisy[ch] = 1'b1;
    en[ch]    = (en_at <= 0);
    c0 = cyc;
    for (int j = 1; j <= n_high; j++) begin
      tick(1);
      if (j - 6 == en_at) en[ch] = 1'b1;
    end
    noisy[ch] = 1'b0;
    fall = cyc;
    tick(12);
    en[ch] = 1'b0;
    check({nm, "_press_cyc"}, 32'(pr_cyc[ch]), 32'(c0 + 6));
    check({nm, "_move_train"}, mv_mask[ch], exp_mv);
    check({nm, "_long_train"}, lg_mask[ch], exp_lg);
    check({nm, "_release_cyc"}, 32'(rl_cyc[ch]), 32'(fall + 6));
  endtask

  initial begin : stimulus
    int c0;
    int r0;
    int f;
    int rc;
    int pc;

    // 1: input high through reset
    rst = 1'b1; noisy = 4'b0001;
    tick(3);
    check("reset_outputs", {12'd0, level_o, press_o, release_o, move_o, long_o}, 32'd0);
    rst = 1'b0; c0 = cyc;
    tick(5);
    check("t1_level_before", 32'(level_o[0]), 32'd0);
    tick(1);
    check("t1_level_rise", 32'(level_o[0]), 32'd1);
    check("t1_press", 32'(press_o[0]), 32'd1);
    check("t1_move", 32'(move_o[0]), 32'd1);
    check("t1_cycle", 32'(cyc - c0), 32'd6);
    tick(1);
    check("t1_press_one_cycle", 32'(press_o[0] | move_o[0]), 32'd0);
    noisy[0] = 1'b0;
    tick(6);
    check("t1_release", 32'(release_o[0]), 32'd1);
    tick(6);

    // 2: glitch, then bounce
    noisy[1] = 1'b1; tick(3);
    noisy[1] = 1'b0; tick(10);
    check("t2_glitch_no_press", 32'(pr_cnt[1]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      noisy[1] = ~noisy[1];
      tick(1);
    end
    noisy[1] = 1'b1; c0 = cyc;
    tick(12);
    check("t2_bounce_one_press", 32'(pr_cnt[1]), 32'd1);
    check("t2_bounce_press_cyc", 32'(pr_cyc[1]), 32'(c0 + 6));
    noisy[1] = 1'b0;
    tick(12);

    // 3 and 4: repeat schedule with and without enable
    hold(0, 30, 0,  32'h12492401, 32'h00100000, "t3");
    check("t3_one_release", 32'(rl_cnt[0]), 32'd2);
    hold(0, 30, 99, 32'h00000001, 32'h00100000, "t4a");
    hold(0, 30, 14, 32'h12490001, 32'h00100000, "t4b");

    // 5: two channels one cycle apart
    pc = pr_cnt[1] + pr_cnt[2];
    en = 4'b1001; noisy = 4'b0001; c0 = cyc;
    tick(1);
    noisy = 4'b1001;
    tick(29);
    noisy = 4'b1000;
    tick(1);
    noisy = 4'b0000;
    tick(12);
    en = 4'b0000;
    check("t5_ch0_move", mv_mask[0], 32'h12492401);
    check("t5_ch3_move", mv_mask[3], 32'h12492401);
    check("t5_ch0_long", lg_mask[0], 32'h00100000);
    check("t5_ch3_long", lg_mask[3], 32'h00100000);
    check("t5_ch0_press_cyc", 32'(pr_cyc[0]), 32'(c0 + 6));
    check("t5_ch3_press_cyc", 32'(pr_cyc[3]), 32'(c0 + 7));
    check("t5_idle_channels", 32'(pr_cnt[1] + pr_cnt[2]), 32'(pc));

    // 6: reset in the middle of a hold
    noisy[0] = 1'b1; en[0] = 1'b1; c0 = cyc;
    tick(18);
    rc = rl_cnt[0];
    rst = 1'b1;
    tick(1);
    check("t6_after_reset", {12'd0, level_o, press_o, release_o, move_o, long_o}, 32'd0);
    rst = 1'b0; r0 = cyc;
    tick(6);
    check("t6_repress", 32'(press_o[0] & move_o[0]), 32'd1);
    check("t6_repress_cyc", 32'(cyc - r0), 32'd6);
    tick(24);
    noisy[0] = 1'b0; f = cyc;
    tick(12);
    en[0] = 1'b0;
    check("t6_no_release_on_reset", 32'(rl_cnt[0]), 32'(rc + 1));
    check("t6_move_train", mv_mask[0], 32'h12492401);
    check("t6_long_train", lg_mask[0], 32'h00100000);
    check("t6_release_cyc", 32'(rl_cyc[0]), 32'(f + 6));

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
